// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_CHK,
    ST_PRESSED,
    ST_RELEASE_CHK
  } btn_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 20000;
  localparam int unsigned LONG_CYCLES_DEF     = 10000000;

  // Width able to hold the larger of the two terminal counts without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the raw button; resets to the idle (released, 1) level.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_conditioner.sv
// Debounced button with press/release pulses, a pending-event flag with overrun,
// and an optional long-press pulse enabled by defining BTN_LONGPRESS_EN.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic btn_level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic evt_valid_o,
  input  logic evt_ack_i,
  output logic evt_overrun_o
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_n_sync;
  logic          pressed;
  btn_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;
  logic          release_q;
  logic          level_q;
  logic          evt_valid_q, evt_valid_d;
  logic          overrun_q, overrun_d;

  btn_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (btn_n_i),
    .q_o (btn_n_sync)
  );

  assign pressed = ~btn_n_sync;

  // The counter only advances while below its terminal value, so it cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RELEASED;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        ST_RELEASED: begin
          if (pressed) begin
            state_q <= ST_PRESS_CHK;
            cnt_q   <= '0;
          end
        end
        ST_PRESS_CHK: begin
          if (!pressed) begin
            state_q <= ST_RELEASED;
          end else if (cnt_q == DB_LAST) begin
            state_q <= ST_PRESSED;
            press_q <= 1'b1;
            level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_PRESSED: begin
          if (!pressed) begin
            state_q <= ST_RELEASE_CHK;
            cnt_q   <= '0;
          end
        end
        ST_RELEASE_CHK: begin
          if (pressed) begin
            state_q <= ST_PRESSED;
          end else if (cnt_q == DB_LAST) begin
            state_q   <= ST_RELEASED;
            release_q <= 1'b1;
            level_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_RELEASED;
      endcase
    end
  end

  // A press landing together with an ack re-arms the event instead of clearing it.
  always_comb begin
    evt_valid_d = evt_valid_q;
    overrun_d   = overrun_q;
    if (press_q) begin
      evt_valid_d = 1'b1;
      if (evt_valid_q && !evt_ack_i) overrun_d = 1'b1;
    end else if (evt_ack_i) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      evt_valid_q <= evt_valid_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef BTN_LONGPRESS_EN
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYCLES);

  logic [CW-1:0] hold_q;
  logic          long_q;

  // Saturation at LONG_CYCLES blocks a repeat until RELEASED clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (state_q == ST_RELEASED) begin
        hold_q <= '0;
      end else if (state_q == ST_PRESSED && hold_q != LONG_SAT) begin
        hold_q <= hold_q + CW'(1);
        if (hold_q == LONG_LAST) long_q <= 1'b1;
      end
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

  assign btn_level_o   = level_q;
  assign press_o       = press_q;
  assign release_o     = release_q;
  assign evt_valid_o   = evt_valid_q;
  assign evt_overrun_o = overrun_q;

endmodule
